// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: byte width and default RX FIFO depth.
package uart_pkg;

   localparam int N_DATA             = 8;
   localparam int RX_FIFO_DEPTH_LOG2 = 4;

   typedef logic [7:0] ovr_cnt_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver, the RX FIFO and its downstream reader.
interface uart_rx_fifo_if
   import uart_pkg::*;
#(
   parameter int N_DATA     = uart_pkg::N_DATA,
   parameter int DEPTH_LOG2 = uart_pkg::RX_FIFO_DEPTH_LOG2
);

   logic [N_DATA-1:0]   i_rx_data;
   logic                i_rx_done;
   logic                i_rd;
   logic                i_clr_ovr;
   logic [N_DATA-1:0]   o_data;
   logic                o_valid;
   logic                o_full;
   logic [DEPTH_LOG2:0] o_count;
   logic                o_overrun;
   ovr_cnt_t            o_ovr_count;

   modport master (
      output i_rx_data, i_rx_done, i_rd, i_clr_ovr,
      input  o_data, o_valid, o_full, o_count, o_overrun, o_ovr_count
   );

   modport slave (
      input  i_rx_data, i_rx_done, i_rd, i_clr_ovr,
      output o_data, o_valid, o_full, o_count, o_overrun, o_ovr_count
   );

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// RX FIFO storage: register array, one synchronous write port, one asynchronous read port.
module rx_fifo_mem #(
   parameter int N_DATA     = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic [DEPTH_LOG2-1:0] i_waddr,
   input  logic [N_DATA-1:0]     i_wdata,
   input  logic [DEPTH_LOG2-1:0] i_raddr,
   output logic [N_DATA-1:0]     o_rdata
);

   logic [N_DATA-1:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge i_clk) begin
      if (i_we) mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with sticky overrun flag.
// Define UART_RX_FIFO_OVR_CNT_EN to build the saturating dropped-byte counter.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int N_DATA     = uart_pkg::N_DATA,
   parameter int DEPTH_LOG2 = uart_pkg::RX_FIFO_DEPTH_LOG2
) (
   input  logic           i_clk,
   input  logic           i_rst,
   uart_rx_fifo_if.slave  bus
);

   localparam int                  DEPTH    = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [DEPTH_LOG2:0]   count_r, count_nxt;
   logic                  vld_p0, full_r, overrun_r;
   logic                  push, pop, drop;

   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   always_comb begin
      pop  = bus.i_rd & vld_p0;
      push = bus.i_rx_done & (~full_r | pop);
      drop = bus.i_rx_done & full_r & ~pop;
      count_nxt = count_r;
      if (push && !pop)      count_nxt = count_r + CNT_ONE;
      else if (pop && !push) count_nxt = count_r - CNT_ONE;
   end

   rx_fifo_mem #(
      .N_DATA     (N_DATA),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_mem (
      .i_clk   (i_clk),
      .i_we    (push & ~i_rst),
      .i_waddr (wr_ptr),
      .i_wdata (bus.i_rx_data),
      .i_raddr (rd_ptr),
      .o_rdata (bus.o_data)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_r   <= '0;
         vld_p0    <= 1'b0;
         full_r    <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         count_r <= count_nxt;
         vld_p0  <= (count_nxt != '0);
         full_r  <= (count_nxt == FULL_CNT);
         // A drop in the same cycle as a clear keeps the flag set.
         if (drop)               overrun_r <= 1'b1;
         else if (bus.i_clr_ovr) overrun_r <= 1'b0;
      end
   end

`ifdef UART_RX_FIFO_OVR_CNT_EN
   ovr_cnt_t ovr_cnt_r;

   function automatic ovr_cnt_t sat_inc(input ovr_cnt_t v);
      return (v == '1) ? v : v + 8'd1;
   endfunction

   // Clear applies first so a coincident drop leaves the counter at 1.
   always_ff @(posedge i_clk) begin
      if (i_rst)              ovr_cnt_r <= '0;
      else if (drop)          ovr_cnt_r <= sat_inc(bus.i_clr_ovr ? '0 : ovr_cnt_r);
      else if (bus.i_clr_ovr) ovr_cnt_r <= '0;
   end

   assign bus.o_ovr_count = ovr_cnt_r;
`else
   assign bus.o_ovr_count = '0;
`endif

   assign bus.o_valid   = vld_p0;
   assign bus.o_full    = full_r;
   assign bus.o_count   = count_r;
   assign bus.o_overrun = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_rx_fifo_if #(.N_DATA(8), .DEPTH_LOG2(4)) bus ();

   uart_rx_fifo #(.N_DATA(8), .DEPTH_LOG2(4)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] q[$];
   bit         m_ovr = 0;
   int         m_cnt = 0;

   function automatic int exp_ovc();
`ifdef UART_RX_FIFO_OVR_CNT_EN
      return m_cnt;
`else
      return 0;
`endif
   endfunction

   // Drive one cycle of inputs and advance the reference model by the same cycle.
   task automatic cyc(input logic r, input logic done, input logic [7:0] d,
                      input logic rd, input logic clr);
      bit pop_ok, push_ok;
      rst = r; bus.i_rx_done = done; bus.i_rx_data = d; bus.i_rd = rd; bus.i_clr_ovr = clr;
      @(posedge clk);
      if (r) begin
         q.delete(); m_ovr = 0; m_cnt = 0;
      end else begin
         pop_ok  = rd && (q.size() > 0);
         push_ok = done && ((q.size() < 16) || pop_ok);
         if (pop_ok)  void'(q.pop_front());
         if (push_ok) q.push_back(d);
         if (done && !push_ok) begin
            m_ovr = 1;
            m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
         end else if (clr) begin
            m_ovr = 0; m_cnt = 0;
         end
      end
      #1;
      rst = 0; bus.i_rx_done = 0; bus.i_rd = 0; bus.i_clr_ovr = 0;
   endtask

   task automatic test_reset();
      cyc(1, 0, 8'h00, 0, 0);
      cyc(1, 0, 8'h00, 0, 0);
      n_tests++; if (bus.o_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.o_count); end
      n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.o_valid); end
      n_tests++; if (bus.o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", bus.o_full); end
      n_tests++; if (bus.o_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b exp 0", bus.o_overrun); end
      n_tests++; if (bus.o_ovr_count !== 8'd0) begin n_fail++; $display("FAIL reset_ovr_count got %0d exp 0", bus.o_ovr_count); end
   endtask

   task automatic test_order();
      logic [7:0] exp_b [3];
      exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
      cyc(0, 1, 8'h11, 0, 0);
      n_tests++; if (bus.o_valid !== 1'b1 || bus.o_data !== 8'h11) begin n_fail++; $display("FAIL order_latency got v=%b d=%h exp v=1 d=11", bus.o_valid, bus.o_data); end
      cyc(0, 1, 8'h22, 0, 0);
      cyc(0, 1, 8'h33, 0, 0);
      n_tests++; if (bus.o_count !== 5'd3) begin n_fail++; $display("FAIL order_count got %0d exp 3", bus.o_count); end
      for (int i = 0; i < 3; i++) begin
         n_tests++; if (bus.o_data !== exp_b[i]) begin n_fail++; $display("FAIL order_data%0d got %h exp %h", i, bus.o_data, exp_b[i]); end
         cyc(0, 0, 8'h00, 1, 0);
         n_tests++; if (bus.o_count !== 5'(2 - i)) begin n_fail++; $display("FAIL order_pop_count%0d got %0d exp %0d", i, bus.o_count, 2 - i); end
      end
      n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL order_end_valid got %b exp 0", bus.o_valid); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 16; i++) cyc(0, 1, 8'(i), 0, 0);
      n_tests++; if (bus.o_full !== 1'b1 || bus.o_count !== 5'd16) begin n_fail++; $display("FAIL ovf_fill got full=%b cnt=%0d exp full=1 cnt=16", bus.o_full, bus.o_count); end
      n_tests++; if (bus.o_overrun !== 1'b0) begin n_fail++; $display("FAIL ovf_pre_overrun got %b exp 0", bus.o_overrun); end
      cyc(0, 1, 8'hAA, 0, 0);
      n_tests++; if (bus.o_overrun !== 1'b1 || bus.o_full !== 1'b1 || bus.o_count !== 5'd16) begin n_fail++; $display("FAIL ovf_drop got ovr=%b full=%b cnt=%0d exp ovr=1 full=1 cnt=16", bus.o_overrun, bus.o_full, bus.o_count); end
      n_tests++; if (int'(bus.o_ovr_count) !== exp_ovc()) begin n_fail++; $display("FAIL ovf_ovr_count got %0d exp %0d", bus.o_ovr_count, exp_ovc()); end
      cyc(0, 1, 8'hAB, 0, 1);
      n_tests++; if (bus.o_overrun !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got %b exp 1", bus.o_overrun); end
      n_tests++; if (int'(bus.o_ovr_count) !== exp_ovc()) begin n_fail++; $display("FAIL ovf_inc_wins got %0d exp %0d", bus.o_ovr_count, exp_ovc()); end
      cyc(0, 0, 8'h00, 0, 1);
      n_tests++; if (bus.o_overrun !== 1'b0 || bus.o_ovr_count !== 8'd0) begin n_fail++; $display("FAIL ovf_clear got ovr=%b cnt=%0d exp 0 0", bus.o_overrun, bus.o_ovr_count); end
      for (int i = 0; i < 16; i++) begin
         n_tests++; if (bus.o_valid !== 1'b1 || bus.o_data !== 8'(i)) begin n_fail++; $display("FAIL ovf_pop%0d got v=%b d=%h exp v=1 d=%h", i, bus.o_valid, bus.o_data, 8'(i)); end
         cyc(0, 0, 8'h00, 1, 0);
      end
      n_tests++; if (bus.o_valid !== 1'b0 || bus.o_count !== 5'd0) begin n_fail++; $display("FAIL ovf_empty got v=%b cnt=%0d exp 0 0", bus.o_valid, bus.o_count); end
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 16; i++) cyc(0, 1, 8'(i), 0, 0);
      cyc(0, 1, 8'h55, 1, 0);
      n_tests++; if (bus.o_overrun !== 1'b0 || bus.o_count !== 5'd16 || bus.o_full !== 1'b1) begin n_fail++; $display("FAIL fpp_state got ovr=%b cnt=%0d full=%b exp 0 16 1", bus.o_overrun, bus.o_count, bus.o_full); end
      for (int i = 0; i < 16; i++) begin
         n_tests++; if (bus.o_data !== q[0]) begin n_fail++; $display("FAIL fpp_pop%0d got %h exp %h", i, bus.o_data, q[0]); end
         if (i == 15) begin
            n_tests++; if (bus.o_data !== 8'h55) begin n_fail++; $display("FAIL fpp_last got %h exp 55", bus.o_data); end
         end
         cyc(0, 0, 8'h00, 1, 0);
      end
   endtask

   task automatic test_empty_push_pop();
      cyc(0, 1, 8'h7E, 1, 0);
      n_tests++; if (bus.o_count !== 5'd1 || bus.o_valid !== 1'b1 || bus.o_data !== 8'h7E) begin n_fail++; $display("FAIL epp_push got cnt=%0d v=%b d=%h exp 1 1 7e", bus.o_count, bus.o_valid, bus.o_data); end
      cyc(0, 0, 8'h00, 1, 0);
      cyc(0, 0, 8'h00, 1, 0);
      n_tests++; if (bus.o_count !== 5'd0 || bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL epp_idle_rd got cnt=%0d v=%b exp 0 0", bus.o_count, bus.o_valid); end
      cyc(0, 1, 8'h12, 0, 0);
      n_tests++; if (bus.o_data !== 8'h12 || bus.o_count !== 5'd1) begin n_fail++; $display("FAIL epp_after got d=%h cnt=%0d exp 12 1", bus.o_data, bus.o_count); end
      cyc(0, 0, 8'h00, 1, 0);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 16; i++) cyc(0, 1, 8'($urandom), 0, 0);
      cyc(0, 1, 8'hEE, 0, 0);
      for (int i = 0; i < 11; i++) cyc(0, 0, 8'h00, 1, 0);
      n_tests++; if (bus.o_count !== 5'd5 || bus.o_overrun !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got cnt=%0d ovr=%b exp 5 1", bus.o_count, bus.o_overrun); end
      cyc(1, 1, 8'h99, 1, 0);
      n_tests++; if (bus.o_count !== 5'd0 || bus.o_valid !== 1'b0 || bus.o_overrun !== 1'b0 || bus.o_ovr_count !== 8'd0) begin n_fail++; $display("FAIL rmid_post got cnt=%0d v=%b ovr=%b oc=%0d exp 0 0 0 0", bus.o_count, bus.o_valid, bus.o_overrun, bus.o_ovr_count); end
      cyc(0, 0, 8'h00, 0, 0);
      n_tests++; if (bus.o_count !== 5'd0 || bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_discard got cnt=%0d v=%b exp 0 0", bus.o_count, bus.o_valid); end
   endtask

   task automatic test_wrap_random();
      logic done, rd, clr;
      for (int i = 0; i < 120; i++) begin
         done = (i < 40) ? 1'b1 : 1'($urandom_range(0, 1));
         rd   = (i < 40) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
         clr  = (i >= 40) && ($urandom_range(0, 7) == 0);
         cyc(0, done, 8'($urandom), rd, clr);
         n_tests++; if (int'(bus.o_count) !== q.size()) begin n_fail++; $display("FAIL rnd_count c%0d got %0d exp %0d", i, bus.o_count, q.size()); end
         n_tests++; if (bus.o_valid !== (q.size() > 0) || bus.o_full !== (q.size() == 16)) begin n_fail++; $display("FAIL rnd_flags c%0d got v=%b f=%b exp v=%b f=%b", i, bus.o_valid, bus.o_full, q.size() > 0, q.size() == 16); end
         n_tests++; if (bus.o_overrun !== m_ovr || int'(bus.o_ovr_count) !== exp_ovc()) begin n_fail++; $display("FAIL rnd_ovr c%0d got %b/%0d exp %b/%0d", i, bus.o_overrun, bus.o_ovr_count, m_ovr, exp_ovc()); end
         if (q.size() > 0) begin
            n_tests++; if (bus.o_data !== q[0]) begin n_fail++; $display("FAIL rnd_data c%0d got %h exp %h", i, bus.o_data, q[0]); end
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      bus.i_rx_data = '0; bus.i_rx_done = 1'b0; bus.i_rd = 1'b0; bus.i_clr_ovr = 1'b0;
      #1;
      test_reset();
      test_order();
      test_overflow();
      test_full_push_pop();
      test_empty_push_pop();
      test_reset_mid();
      test_wrap_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter N_DATA, default 8, meaning byte width.
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 4, meaning log2 of FIFO depth (16 entries).
REQ-003 The block SHALL have port i_clk  input  1  single system clock, all logic on rising edge.
REQ-004 The block SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port i_rx_data  input  N_DATA  byte from the upstream UART receiver.
REQ-006 The block SHALL have port i_rx_done  input  1  one-cycle push strobe qualifying i_rx_data.
REQ-007 The block SHALL have port i_rd  input  1  pop request from the downstream UART/ALU interface.
REQ-008 The block SHALL have port i_clr_ovr  input  1  clears the sticky overrun flag.
REQ-009 The block SHALL have port o_data  output  N_DATA  head-of-FIFO byte, first-word-fall-through.
REQ-010 The block SHALL have port o_valid  output  1  FIFO not empty; o_data meaningful.
REQ-011 The block SHALL have port o_full  output  1  FIFO holds 2^DEPTH_LOG2 entries.
REQ-012 The block SHALL have port o_count  output  DEPTH_LOG2+1  current occupancy.
REQ-013 The block SHALL have port o_overrun  output  1  sticky: a byte was dropped.
REQ-014 The block SHALL have port o_ovr_count  output  8  dropped-byte counter (see Configuration).

Function
REQ-015 The block SHALL write i_rx_data on a cycle with i_rx_done=1 and not full, or full with a simultaneous accepted pop.
REQ-016 The block SHALL make a written byte visible (o_valid=1, o_data) in the cycle after the push when the FIFO was empty: 1-cycle latency.
REQ-017 The block SHALL pop on a cycle with i_rd=1 and o_valid=1; o_data SHALL show the next entry in the following cycle.
REQ-018 The block SHALL ignore i_rd while o_valid=0: no pointer or count change.
REQ-019 The block SHALL, on simultaneous push and pop with 0<count<full, perform both with count unchanged.
REQ-020 The block SHALL, on simultaneous push and pop when full, perform both: o_full stays 1 and the new byte is stored.
REQ-021 The block SHALL, on simultaneous push and pop when empty, accept the push and ignore the pop; count becomes 1.
REQ-022 The block SHALL drop a push when full without a pop, leave contents unchanged, and set o_overrun the next cycle.
REQ-023 The block SHALL hold o_overrun until reset or i_clr_ovr; a new drop in the same cycle as i_clr_ovr SHALL leave it set (set wins).
REQ-024 The block SHALL wrap read/write pointers modulo 2^DEPTH_LOG2; o_count SHALL stay in 0..2^DEPTH_LOG2.
REQ-025 The block SHALL drive o_full and o_valid as registered outputs, consistent with o_count in the same cycle.

Reset
REQ-026 The block SHALL, on i_rst=1 at a clock edge, clear pointers, o_count=0, o_valid=0, o_full=0, o_overrun=0, o_ovr_count=0.
REQ-027 The block SHALL treat reset mid-operation as flushing all stored bytes; a push or pop coinciding with reset SHALL be discarded.
REQ-028 The block SHALL NOT need the storage array reset; o_data SHALL be don't-care while o_valid=0.

Configuration
REQ-029 With macro UART_RX_FIFO_OVR_CNT_EN defined, the block SHALL increment o_ovr_count on every dropped byte, saturate at 255, and clear it with i_clr_ovr (increment wins on same-cycle conflict, giving 1).
REQ-030 Without UART_RX_FIFO_OVR_CNT_EN, the block SHALL tie o_ovr_count to 0 and implement no counter logic; the port list stays identical.

Structure
REQ-031 The package uart_pkg SHALL hold the shared N_DATA byte-width constant and the default FIFO depth constant RX_FIFO_DEPTH_LOG2.
REQ-032 The storage SHALL be one sub-module rx_fifo_mem: a register array with one synchronous write port and one asynchronous read port; pointer/flag control stays in uart_rx_fifo.

Verification
REQ-033 The bench SHALL push 0x11,0x22,0x33 on separate cycles, then pop 3 times: o_data 0x11,0x22,0x33 in order, o_count 3->0, o_valid 0 at end.
REQ-034 The bench SHALL push 16 bytes 0x00..0x0F, then push 0xAA: o_full=1, o_overrun=1, 0xAA not stored, 16 pops return 0x00..0x0F, o_ovr_count=1 (macro on) / 0 (off).
REQ-035 With the FIFO full, the bench SHALL push 0x55 with simultaneous i_rd: o_overrun stays 0, o_count stays 16, the 16th pop returns 0x55.
REQ-036 With the FIFO empty, the bench SHALL assert i_rd plus push 0x7E: count becomes 1, o_data=0x7E next cycle; i_rd alone on empty changes nothing.
REQ-037 With 5 bytes stored and o_overrun=1, the bench SHALL assert i_rst for one cycle: o_count=0, o_valid=0, o_overrun=0, o_ovr_count=0 next cycle.
REQ-038 The bench SHALL run 40 push/pop cycles forcing pointer wrap twice, with order checked against a reference queue model.
